// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one shift-add multiplier between two
// requesters, sequencing St/Done and returning each product with a one-cycle Ack.
module mult_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req0,
    input  logic        Req1,
    input  logic [15:0] A0,
    input  logic [15:0] B0,
    input  logic [15:0] A1,
    input  logic [15:0] B1,
    output logic        Ack0,
    output logic        Ack1,
    output logic [31:0] Result0,
    output logic [31:0] Result1,
    output logic [1:0]  Gnt,
    output logic        Err,
    output logic        St,
    output logic [15:0] Multiplicando,
    output logic [15:0] Multiplicador,
    input  logic [31:0] Produto,
    input  logic        Idle,
    input  logic        Done
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic            r_win;
    logic            w_win_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [1:0]      r_gnt;
    logic [1:0]      w_gnt_nxt;
    logic            r_st;
    logic            w_st_nxt;
    logic            r_ack0;
    logic            w_ack0_nxt;
    logic            r_ack1;
    logic            w_ack1_nxt;
    logic [31:0]     r_res0;
    logic [31:0]     w_res0_nxt;
    logic [31:0]     r_res1;
    logic [31:0]     w_res1_nxt;
    logic [15:0]     r_mcand;
    logic [15:0]     w_mcand_nxt;
    logic [15:0]     r_mplier;
    logic [15:0]     w_mplier_nxt;
    logic            r_err;
    logic            w_err_nxt;

    logic            w_pick;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_timeout;

    // r_last remembers the port served most recently; on a tie the other port wins
    assign w_pick    = (Req0 && Req1) ? ~r_last : Req1;
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_timeout = (w_cnt_inc == CW'(TIMEOUT));

    // Next-state and next-output decode for the sequencer
    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last;
        w_win_nxt    = r_win;
        w_cnt_nxt    = r_cnt;
        w_gnt_nxt    = r_gnt;
        w_st_nxt     = 1'b0;
        w_ack0_nxt   = 1'b0;
        w_ack1_nxt   = 1'b0;
        w_res0_nxt   = r_res0;
        w_res1_nxt   = r_res1;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_err_nxt    = r_err;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = 2'b00;
                if (Idle && (Req0 || Req1)) begin
                    w_win_nxt    = w_pick;
                    w_mcand_nxt  = w_pick ? A1 : A0;
                    w_mplier_nxt = w_pick ? B1 : B0;
                    w_gnt_nxt    = w_pick ? 2'b10 : 2'b01;
                    w_st_nxt     = 1'b1;
                    w_state_nxt  = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                w_cnt_nxt   = {CW{1'b0}};
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Done takes precedence over a watchdog expiry in the same cycle
                if (Done) begin
                    if (r_win) begin
                        w_res1_nxt = Produto;
                        w_ack1_nxt = 1'b1;
                    end else begin
                        w_res0_nxt = Produto;
                        w_ack0_nxt = 1'b1;
                    end
                    w_state_nxt = S_ACK;
                end else if (w_timeout) begin
                    if (r_win) begin
                        w_res1_nxt = 32'd0;
                        w_ack1_nxt = 1'b1;
                    end else begin
                        w_res0_nxt = 32'd0;
                        w_ack0_nxt = 1'b1;
                    end
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_ACK;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_ACK: begin
                w_last_nxt  = r_win;
                w_gnt_nxt   = 2'b00;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_gnt_nxt   = 2'b00;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, priority, watchdog and output registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_win    <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            r_gnt    <= 2'b00;
            r_st     <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_res0   <= 32'd0;
            r_res1   <= 32'd0;
            r_mcand  <= 16'd0;
            r_mplier <= 16'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last   <= w_last_nxt;
            r_win    <= w_win_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gnt    <= w_gnt_nxt;
            r_st     <= w_st_nxt;
            r_ack0   <= w_ack0_nxt;
            r_ack1   <= w_ack1_nxt;
            r_res0   <= w_res0_nxt;
            r_res1   <= w_res1_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign Ack0          = r_ack0;
    assign Ack1          = r_ack1;
    assign Result0       = r_res0;
    assign Result1       = r_res1;
    assign Gnt           = r_gnt;
    assign Err           = r_err;
    assign St            = r_st;
    assign Multiplicando = r_mcand;
    assign Multiplicador = r_mplier;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: a multiplier model plus a transaction-timeline reference model,
// compared against the DUT every cycle, with directed scenarios and a randomized phase.
module tb_mult_arbiter;
    localparam int TIMEOUT = 64;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Req0 = 1'b0, Req1 = 1'b0;
    logic [15:0] A0 = 16'd0, B0 = 16'd0, A1 = 16'd0, B1 = 16'd0;
    logic        Ack0, Ack1, Err, St;
    logic [31:0] Result0, Result1;
    logic [1:0]  Gnt;
    logic [15:0] Multiplicando, Multiplicador;
    logic [31:0] Produto = 32'd0;
    logic        Idle = 1'b1;
    logic        Done = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    mult_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .Ack0(Ack0), .Ack1(Ack1), .Result0(Result0), .Result1(Result1),
        .Gnt(Gnt), .Err(Err), .St(St),
        .Multiplicando(Multiplicando), .Multiplicador(Multiplicador),
        .Produto(Produto), .Idle(Idle), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // multiplier-model knobs (written by the stimulus process only)
    int lat = 10, dlen = 1, hold_start = 0, hold_len = 0;
    bit never_done = 1'b0, spur_en = 1'b0;

    // observations (written by the environment process only)
    int cyc = 0, n_st = 0, n_ack0 = 0, n_ack1 = 0, st_cyc = 0, ack0_cyc = 0;
    logic [1:0] gnt_at_st = 2'b00;
    int ackq[$];

    // reference model: one transaction at a time, described by owner, St cycle s, Ack cycle e
    bit m_act = 1'b0, m_win = 1'b0, m_last = 1'b1, m_err = 1'b0;
    int m_s = 0, m_e = 0;
    logic [31:0] m_res0 = 32'd0, m_res1 = 32'd0;
    logic [15:0] m_mc = 16'd0, m_mp = 16'd0;

    bit mu_busy = 1'b0;
    int mu_cnt = 0, mu_dlen = 0;
    logic [31:0] mu_prod = 32'd0;

    initial forever begin
        logic [1:0] eg;
        bit h_active;
        @(negedge Clk);
        if (St) begin n_st++; st_cyc = cyc; gnt_at_st = Gnt; end
        if (Ack0) begin n_ack0++; ack0_cyc = cyc; ackq.push_back(0); end
        if (Ack1) begin n_ack1++; ackq.push_back(1); end
        if (!Rst) begin
            eg = (m_act && cyc >= m_s) ? (m_win ? 2'b10 : 2'b01) : 2'b00;
            chk("gnt",   32'(Gnt), 32'(eg));
            chk("st",    32'(St), 32'(m_act && cyc == m_s));
            chk("ack0",  32'(Ack0), 32'(m_act && m_e != 0 && cyc == m_e && !m_win));
            chk("ack1",  32'(Ack1), 32'(m_act && m_e != 0 && cyc == m_e && m_win));
            chk("res0",  Result0, m_res0);
            chk("res1",  Result1, m_res1);
            chk("mcand", 32'(Multiplicando), 32'(m_mc));
            chk("mplr",  32'(Multiplicador), 32'(m_mp));
            chk("err",   32'(Err), 32'(m_err));
        end
        // multiplier model: inputs applied now are what the DUT samples at the next edge
        h_active = (cyc >= hold_start) && (cyc < hold_start + hold_len);
        if (St && !never_done && !mu_busy) begin
            mu_busy = 1'b1; mu_cnt = lat; mu_dlen = dlen;
            mu_prod = 32'(Multiplicando) * 32'(Multiplicador);
        end
        if (mu_busy) begin
            Idle = 1'b0;
            if (mu_cnt > 0) begin
                mu_cnt--; Done = 1'b0; Produto = $urandom;
            end else begin
                Done = 1'b1; Produto = mu_prod; mu_dlen--;
                if (mu_dlen == 0) mu_busy = 1'b0;
            end
        end else begin
            Idle = !h_active;
            Done = spur_en && !never_done && ($urandom_range(0, 5) == 0);
            Produto = $urandom;
        end
        if (Rst) begin
            m_act = 1'b0; m_last = 1'b1; m_err = 1'b0;
            m_res0 = 32'd0; m_res1 = 32'd0; m_mc = 16'd0; m_mp = 16'd0;
        end else if (m_act && m_e != 0 && cyc == m_e) begin
            m_act = 1'b0; m_last = m_win;
        end else if (m_act) begin
            if (m_e == 0 && cyc > m_s) begin
                if (Done) begin
                    m_e = cyc + 1;
                    if (m_win) m_res1 = Produto; else m_res0 = Produto;
                end else if (cyc - m_s == TIMEOUT) begin
                    m_e = cyc + 1; m_err = 1'b1;
                    if (m_win) m_res1 = 32'd0; else m_res0 = 32'd0;
                end
            end
        end else if (Idle && (Req0 || Req1)) begin
            if (Req0 && Req1) m_win = (m_last == 1'b0);
            else m_win = Req1;
            m_mc = m_win ? A1 : A0;
            m_mp = m_win ? B1 : B0;
            m_s = cyc + 1; m_e = 0; m_act = 1'b1;
        end
        cyc++;
    end

    task automatic do_req(input int port, input logic [15:0] a, input logic [15:0] b);
        bit got;
        @(posedge Clk); #2;
        if (port == 0) begin Req0 = 1'b1; A0 = a; B0 = b; end
        else begin Req1 = 1'b1; A1 = a; B1 = b; end
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge Clk);
            got = (port == 0) ? Ack0 : Ack1;
        end
        chk($sformatf("req%0d_ack_seen", port), 32'(got), 32'd1);
        @(posedge Clk); #2;
        if (port == 0) Req0 = 1'b0; else Req1 = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge Clk); #2; Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #2; Rst = 1'b0;
    endtask

    initial begin
        int st0, a0, a1, q0;
        bit got;
        #1 Rst = 1'b1;
        #2;
        chk("rst_st", 32'(St), 32'd0);
        chk("rst_gnt", 32'(Gnt), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_res0", Result0, 32'd0);
        repeat (3) @(posedge Clk);
        #2 Rst = 1'b0;

        // single request, latency 34
        lat = 34; st0 = n_st; a0 = n_ack0; a1 = n_ack1;
        do_req(0, 16'd2000, 16'd2000);
        chk("single_st_count", 32'(n_st - st0), 32'd1);
        chk("single_gnt", 32'(gnt_at_st), 32'd1);
        chk("single_ack0", 32'(n_ack0 - a0), 32'd1);
        chk("single_ack1", 32'(n_ack1 - a1), 32'd0);
        chk("single_res0", Result0, 32'h003D0900);

        // simultaneous requests right after reset
        pulse_rst();
        lat = 12; st0 = n_st; q0 = ackq.size();
        fork
            do_req(0, 16'd3, 16'd5);
            do_req(1, 16'hFFFF, 16'hFFFF);
        join
        chk("sim_res0", Result0, 32'd15);
        chk("sim_res1", Result1, 32'hFFFE0001);
        chk("sim_st_count", 32'(n_st - st0), 32'd2);
        chk("sim_ack_count", 32'(ackq.size() - q0), 32'd2);
        chk("sim_first", 32'(ackq[q0]), 32'd0);

        // round-robin fairness over 6 operations
        lat = 7; q0 = ackq.size();
        repeat (3) fork
            do_req(0, 16'($urandom), 16'($urandom));
            do_req(1, 16'($urandom), 16'($urandom));
        join
        chk("rr_count", 32'(ackq.size() - q0), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), 32'(ackq[q0 + i]), 32'(i % 2));

        // watchdog timeout, then normal completion with Err still set
        never_done = 1'b1;
        do_req(0, 16'd7, 16'd9);
        chk("to_latency", 32'(ack0_cyc - st_cyc), 32'd65);
        chk("to_res0", Result0, 32'd0);
        chk("to_err", 32'(Err), 32'd1);
        never_done = 1'b0; lat = 5;
        do_req(1, 16'd100, 16'd3);
        chk("to_next_res1", Result1, 32'd300);
        chk("to_err_sticky", 32'(Err), 32'd1);

        // asynchronous reset in the middle of WAIT
        lat = 40; a0 = n_ack0;
        @(posedge Clk); #2; Req0 = 1'b1; A0 = 16'd21; B0 = 16'd22;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin @(negedge Clk); got = St; end
        chk("mid_st_seen", 32'(got), 32'd1);
        repeat (10) @(posedge Clk);
        #3 Rst = 1'b1;
        #1;
        chk("mid_st", 32'(St), 32'd0);
        chk("mid_gnt", 32'(Gnt), 32'd0);
        chk("mid_ack", 32'({Ack0, Ack1}), 32'd0);
        chk("mid_res", Result0 | Result1, 32'd0);
        chk("mid_ops", 32'({Multiplicando, Multiplicador}), 32'd0);
        chk("mid_err", 32'(Err), 32'd0);
        Req0 = 1'b0;
        repeat (2) @(posedge Clk);
        #2 Rst = 1'b0;
        repeat (4) @(posedge Clk);
        chk("mid_no_ack", 32'(n_ack0 - a0), 32'd0);
        lat = 6; q0 = ackq.size();
        fork
            do_req(0, 16'd11, 16'd13);
            do_req(1, 16'd17, 16'd19);
        join
        chk("mid_prio", 32'(ackq[q0]), 32'd0);
        chk("mid_res0", Result0, 32'd143);

        // Idle held low for 8 cycles while a request is pending
        @(posedge Clk); #2;
        hold_start = cyc; hold_len = 8;
        Req0 = 1'b1; A0 = 16'd9; B0 = 16'd9;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin @(negedge Clk); got = Ack0; end
        chk("hold_ack", 32'(got), 32'd1);
        chk("hold_st_cycle", 32'(st_cyc), 32'(hold_start + 9));
        @(posedge Clk); #2; Req0 = 1'b0;

        // randomized traffic with spurious Done and variable latency
        spur_en = 1'b1;
        for (int it = 0; it < 25; it++) begin
            int pat;
            lat = $urandom_range(1, 30);
            dlen = $urandom_range(1, 2);
            pat = $urandom_range(1, 3);
            if ($urandom_range(0, 4) == 0) begin
                hold_start = cyc + 1; hold_len = $urandom_range(1, 6);
            end
            fork
                begin if (pat % 2 == 1) do_req(0, 16'($urandom), 16'($urandom)); end
                begin if (pat >= 2) do_req(1, 16'($urandom), 16'($urandom)); end
            join
        end
        repeat (3) @(posedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Two-port arbiter and sequencer for the shared 16x16 shift-add multiplier (`Multiplicador`). Accepts multiply requests from two independent requesters, grants the multiplier round-robin, drives its `St`/operand inputs, waits for `Done`, and returns the 32-bit product to the granted requester with a one-cycle acknowledge. A watchdog flags a multiplier that never completes.

## Interface
- `TIMEOUT`, 64: maximum cycles in WAIT before an abort; counter width `$clog2(TIMEOUT+1)`.
- `Clk` in 1: single clock, all state updates on the rising edge.
- `Rst` in 1: reset, asynchronous, active-high.
- `Req0`, `Req1` in 1: request from requester 0/1; held high until the matching Ack.
- `A0`, `B0`, `A1`, `B1` in 16: unsigned operands, stable while the matching Req is high.
- `Ack0`, `Ack1` out 1: one-cycle pulse, result valid.
- `Result0`, `Result1` out 32: registered product, held until overwritten by that port's next Ack.
- `Gnt` out 2: one-hot current owner; `2'b00` when free.
- `Err` out 1: sticky timeout flag, cleared only by `Rst`.
- `St` out 1: start pulse to the multiplier.
- `Multiplicando`, `Multiplicador` out 16: registered operands to the multiplier.
- `Produto` in 32: multiplier product, valid while `Done`=1.
- `Idle` in 1: multiplier ready to accept `St`.
- `Done` in 1: multiplier completion, high at least one cycle.

## Operation
- States: IDLE, START, WAIT, ACK.
- IDLE: `Gnt`=0. When `Idle`=1 and any Req is high, select a winner, latch its A/B into `Multiplicando`/`Multiplicador`, set `Gnt`, go START. If `Idle`=0, stay.
- Arbitration: with one Req high, that port wins. With both high, the port not served most recently wins. Priority pointer resets to port 0 and toggles only on completion (Ack).
- START: `St`=1 for exactly this cycle. Clear watchdog counter. Go WAIT.
- WAIT: `St`=0, operands held. Counter increments each cycle. `Done`=1: capture `Produto` into the winner's Result, go ACK. Counter reaches `TIMEOUT` without `Done`: write 0 to the winner's Result, set `Err`, go ACK.
- ACK: winner's Ack=1 for this cycle only. Toggle priority pointer. Clear `Gnt`. Go IDLE.
- Requester contract: Req must be low in the cycle after Ack. A Req still high then is treated as a new request.
- Req falling before Ack is a protocol violation. The operation still completes and Ack still pulses.
- `Done` in IDLE, START or ACK is ignored.
- `Done` and timeout in the same WAIT cycle: `Done` wins and `Err` is not set.
- Arithmetic: unsigned. `Result` is `Produto` verbatim with no truncation.

## Timing
- Reset (async): state IDLE, pointer = port 0, counter 0. All outputs 0: `St`, `Gnt`, `Ack0/1`, `Result0/1`, `Multiplicando`, `Multiplicador`, `Err`.
- Reset mid-operation: return to IDLE immediately, with no Ack and no Result update. After reset, the multiplier is started only once `Idle`=1.
- Req sampled high in IDLE cycle n:
  - `Gnt` and operands valid in n+1.
  - `St`=1 in n+1.
  - WAIT from n+2.
- `Done` high in cycle d: Ack and the new Result are visible in d+1, `Gnt`=0 in d+2, and the next grant is possible in d+2.
- Back-to-back overhead per operation, excluding multiplier latency: 3 cycles (IDLE, START, ACK).
- Timeout: with no `Done`, ACK occurs `TIMEOUT`+1 cycles after START.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Single request: `Req0`, A0=2000, B0=2000, multiplier model with latency 34 cycles.
  - Expect one `St` pulse and `Gnt`=01.
  - Expect `Ack0` once, with `Result0`=4000000 (0x003D0900).
  - `Ack1` never asserts.
- Simultaneous requests after reset: `Req0` (3x5) and `Req1` (0xFFFF x 0xFFFF) both held.
  - Port 0 is served first: `Result0`=15.
  - Port 1 is served next: `Result1`=0xFFFE0001.
  - Exactly two `St` pulses, each while `Idle`=1.
- Round-robin fairness: both Reqs re-raised every time, for 6 operations.
  - Acks alternate 0,1,0,1,0,1.
  - No port is served twice in a row.
- Timeout: model never asserts `Done`, `TIMEOUT`=64.
  - `Ack0` occurs 65 cycles after `St`, with `Result0`=0 and `Err`=1 sticky.
  - The next request still completes normally, and `Err` stays 1.
- Reset mid-WAIT: assert `Rst` asynchronously 10 cycles after `St`.
  - All outputs go to 0 immediately and no Ack is issued.
  - After release, a new request works and port 0 has priority.
- `Idle`=0 hold-off: Req raised while the model holds `Idle`=0 for 8 cycles.
  - `St` stays 0 until the first cycle after `Idle` returns to 1.
